// File: rtl/serial_pair_serializer_msb_first.sv
// serial_pair_serializer_msb_first: streams accepted (A,B) word pairs as two MSB-first bit lanes with a one-word hold buffer
module serial_pair_serializer_msb_first #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [WIDTH-1:0] sh_a, sh_b, hd_a, hd_b;
  logic [CW-1:0] cnt;
  logic busy, hold_full, acc, xfer, last;
  assign acc = in_valid && !hold_full;
  assign xfer = busy && out_ready;
  assign last = cnt == LAST;
  assign in_ready = !hold_full;
  assign out_valid = busy;
  assign out_a = sh_a[WIDTH-1];
  assign out_b = sh_b[WIDTH-1];
  assign out_first = busy && cnt == '0;
  assign out_last = busy && last;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh_a <= '0;
      sh_b <= '0;
      hd_a <= '0;
      hd_b <= '0;
      cnt <= '0;
      busy <= 1'b0;
      hold_full <= 1'b0;
    end else begin
      if (xfer && !last) begin
        sh_a <= sh_a << 1;
        sh_b <= sh_b << 1;
        cnt <= cnt + 1'b1;
      end else if (xfer) begin
        cnt <= '0;
        if (hold_full) begin
          sh_a <= hd_a;
          sh_b <= hd_b;
          hold_full <= 1'b0;
        end else if (acc) begin
          sh_a <= in_a;
          sh_b <= in_b;
        end else busy <= 1'b0;
      end else if (!busy && acc) begin
        sh_a <= in_a;
        sh_b <= in_b;
        busy <= 1'b1;
        cnt <= '0;
      end
      // a word arriving mid-stream parks in the hold until the current word's last bit leaves
      if (busy && acc && !(xfer && last)) begin
        hd_a <= in_a;
        hd_b <= in_b;
        hold_full <= 1'b1;
      end
    end
endmodule

// File: tb/tb_serial_pair_serializer_msb_first.sv
// tb_serial_pair_serializer_msb_first: queue-based scoreboard for the 16-bit build plus a directed 1-bit build check
module tb_serial_pair_serializer_msb_first;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, out_a, out_b, out_first, out_last;
  logic [15:0] in_a = 0, in_b = 0;
  logic v1 = 0, r1, ov1, oa1, ob1, f1, l1;
  logic [0:0] a1 = 0, b1 = 0;
  int tests = 0, fails = 0, mode = 0, ph = 0, bi = 0;
  logic run = 0, stall_prev = 0;
  logic [3:0] prev;
  logic [31:0] q[$];
  serial_pair_serializer_msb_first #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_first(out_first), .out_last(out_last));
  serial_pair_serializer_msb_first #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1),
    .out_valid(ov1), .out_ready(1'b1), .out_a(oa1), .out_b(ob1),
    .out_first(f1), .out_last(l1));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    ph++;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? (ph % 4 == 0 || ph % 4 == 3) : mode == 2 ? 1'b0 : 1'($urandom % 2);
  end
  // model: a word is pending from its accept until its 16th bit is taken; hold capacity makes the limit two
  always @(negedge clk) if (run && !rst) begin
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (stall_prev) chk("stall_hold", {out_valid, out_a, out_b, out_first, out_last}, {1'b1, prev});
    if (out_valid && out_ready && q.size() > 0) begin
      logic [31:0] w;
      w = q[0];
      chk("bit_a", out_a, w[31-bi]);
      chk("bit_b", out_b, w[15-bi]);
      chk("first", out_first, bi == 0);
      chk("last", out_last, bi == 15);
      bi++;
      if (bi == 16) begin
        void'(q.pop_front());
        bi = 0;
      end
    end
    stall_prev = out_valid && !out_ready;
    prev = {out_a, out_b, out_first, out_last};
    if (in_valid && in_ready) q.push_back({in_a, in_b});
  end
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 0;
    while (q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #3;
    chk("rst_valid", {out_valid, out_first, out_last, ov1, f1, l1}, 0);
    chk("rst_ready", {in_ready, r1}, 2'b11);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    v1 = 1; a1 = 1; b1 = 0;
    @(negedge clk);
    chk("w1_ready", r1, 1);
    @(posedge clk);
    #1;
    a1 = 0; b1 = 1;
    @(negedge clk);
    chk("w1_bit0", {ov1, oa1, ob1, f1, l1, r1}, 6'b110111);
    @(posedge clk);
    #1;
    v1 = 0;
    @(negedge clk);
    chk("w1_bit1", {ov1, oa1, ob1, f1, l1}, 5'b10111);
    @(negedge clk);
    chk("w1_idle", ov1, 0);
    run = 1;
    send(16'h4126, 16'h4646);
    drain();
    send(16'h4106, 16'h5646);
    send(16'h4726, 16'h4726);
    drain();
    mode = 1;
    for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom));
    drain();
    mode = 2;
    send(16'hA5C3, 16'h0FF0);
    send(16'h8001, 16'h7FFE);
    in_a = 16'h1234; in_b = 16'hFEDC;
    repeat (6) @(posedge clk);
    #1;
    mode = 0;
    send(16'h1234, 16'hFEDC);
    drain();
    send(16'hFFFF, 16'h0000);
    send(16'hC0DE, 16'hBEEF);
    in_valid = 0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_out", {out_valid, out_first, out_last}, 0);
    chk("mid_rst_ready", in_ready, 1);
    q.delete();
    bi = 0;
    stall_prev = 0;
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    send(16'h9669, 16'h3C3C);
    drain();
    mode = 3;
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom % 2);
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      @(posedge clk);
      #1;
    end
    mode = 0;
    drain();
    run = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_pair_serializer_msb_first.md
Name: serial_pair_serializer_msb_first

Overview:
- Upstream feeder for the MSB-first serial comparator.
- Accepts a pair of WIDTH-bit words (A, B) over a valid/ready handshake and streams them as two synchronous 1-bit lanes, most significant bit first.
- Marks the first and last bit of each word so the consumer can restart its comparison state per word.
- Has a one-word holding buffer, so back-to-back words stream with no bubble between them.

Parameters:
- WIDTH, 16, bits per word; legal range 1 to 64.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  word pair available on in_a/in_b
- in_ready  output  1  block can accept a word pair this cycle
- in_a  input  WIDTH  word A
- in_b  input  WIDTH  word B
- out_valid  output  1  out_a/out_b/out_first/out_last carry a valid bit
- out_ready  input  1  consumer takes the current bit
- out_a  output  1  current bit of A
- out_b  output  1  current bit of B
- out_first  output  1  current bit is the MSB (bit WIDTH-1) of its word
- out_last  output  1  current bit is the LSB (bit 0) of its word

Behaviour:
- Handshake events:
  - Input accept: in_valid && in_ready.
  - Bit transfer: out_valid && out_ready.
  - in_a/in_b are sampled only on accept.
- State:
  - Shifter: sh_a, sh_b, bit counter cnt (0..WIDTH-1), busy flag.
  - Holding register: hd_a, hd_b, hold_full flag.
- Outputs (combinational from registers only; no combinational in-to-out path):
  - out_valid = busy.
  - out_a = sh_a[WIDTH-1], out_b = sh_b[WIDTH-1].
  - out_first = busy && cnt==0.
  - out_last = busy && cnt==WIDTH-1.
  - in_ready = !hold_full.
- Reset values (asynchronous, during and after rst):
  - busy=0, hold_full=0, cnt=0, so out_valid/out_first/out_last=0 and in_ready=1.
  - Data registers = 0.
- Transfer, not last bit: shift sh_a/sh_b left by 1, cnt+1.
- Transfer on last bit (word done):
  - If hold_full: load shifter from hold, cnt=0, busy stays 1, hold_full=0.
  - Else if input accepted same cycle: load shifter from in_a/in_b, cnt=0, busy stays 1.
  - Else: busy=0, cnt=0.
- Accept while busy=0: load shifter directly, busy=1, cnt=0. Latency from accept edge to first out_valid is 1 cycle.
- Accept while busy=1 and not a last-bit transfer: load hold, hold_full=1. in_ready drops the next cycle.
- Accept on the same edge as a last transfer with hold_full=1 cannot occur, because in_ready=0.
- Stall: while out_ready=0, all shifter state and outputs hold. Output bits stay stable until transferred. Input is still accepted into the hold if it is free.
- Throughput: one word per WIDTH cycles sustained, no idle cycle between words when the hold is kept filled.
- WIDTH=1: out_first and out_last are both high on every valid bit; every transfer is a last transfer.
- Reset mid-word discards both the in-flight and held words. The next output is the first word accepted after reset.

Test Plan:
- Single word, out_ready=1, in_a=16'h4126, in_b=16'h4646, accepted at cycle 0:
  - out_valid high cycles 1..16.
  - out_a sequence 0,1,0,0,0,0,0,1,0,0,1,0,0,1,1,0; out_b likewise from 16'h4646.
  - out_first at cycle 1 only, out_last at cycle 16 only, out_valid=0 at cycle 17.
- Back-to-back, in_valid held high with words 16'h4106/16'h5646 then 16'h4726/16'h4726, out_ready=1:
  - Second word's MSB appears at cycle 17 with out_first=1, no gap.
  - in_ready=0 while the hold is full.
- Backpressure: out_ready toggled 1,0,0,1 repeating:
  - Bits and first/last flags hold steady during stalls.
  - Reassembled words equal the inputs; each word still takes exactly 16 transfers.
- Full-buffer boundary: accept three words with out_ready=0:
  - Two accepted; third sees in_ready=0 until word 1's last transfer completes.
  - in_ready rises the cycle after the hold empties.
- Reset asserted asynchronously mid-word (after 5 transfers, hold full):
  - out_valid, out_first, out_last go to 0 immediately; in_ready goes to 1.
  - The next accepted word is streamed from its MSB with out_first=1.
- WIDTH=1 build, words 1/0 then 0/1:
  - Each valid bit shows out_first=out_last=1.
  - Outputs are (1,0) then (0,1) on consecutive cycles.
